// File: rtl/seg7_scan_hhmmss_pkg.sv
// Shared constants for the HH:MM:SS multiplexed seven-segment scanner.
package seg7_scan_hhmmss_pkg;

    localparam int unsigned NUM_DIGITS = 6;

    // Segment patterns {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;

    // Field indices, matching bit positions of the blink mask
    localparam int unsigned SECONDS = 0;
    localparam int unsigned MINUTES = 1;
    localparam int unsigned HOURS   = 2;

    // Digit index (0 = S1 .. 5 = H10) to the field it belongs to
    function automatic logic [1:0] field_of(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1: field_of = 2'(SECONDS);
            3'd2, 3'd3: field_of = 2'(MINUTES);
            default:    field_of = 2'(HOURS);
        endcase
    endfunction

endpackage

// File: rtl/seg7_scan_hhmmss_if.sv
// Time input, display controls and display drive lines of the scanner.
interface seg7_scan_hhmmss_if;
    import seg7_scan_hhmmss_pkg::*;

    logic [4*NUM_DIGITS-1:0] i_time;
    logic [2:0]              i_blink_mask;
    logic [NUM_DIGITS-1:0]   i_dp_mask;
    logic [6:0]              o_seg;
    logic                    o_dp;
    logic [NUM_DIGITS-1:0]   o_an;
    logic                    o_frame;

    modport master (
        output i_time, i_blink_mask, i_dp_mask,
        input  o_seg, o_dp, o_an, o_frame
    );

    modport slave (
        input  i_time, i_blink_mask, i_dp_mask,
        output o_seg, o_dp, o_an, o_frame
    );

endinterface

// File: rtl/seg7_scan_hhmmss_bcd_to_seg7.sv
// Combinational BCD nibble to active-high seven-segment decoder.
module bcd_to_seg7
    import seg7_scan_hhmmss_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Digits 0-9 decode normally, everything else shows a dash
    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_hhmmss.sv
// Multiplexed 6-digit HH:MM:SS seven-segment scanner with per-frame
// time snapshot, field blinking and decimal points.
module seg7_scan_hhmmss
    import seg7_scan_hhmmss_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 1000,
    parameter int unsigned BLINK_DIV  = 128,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_en,
    seg7_scan_hhmmss_if.slave    bus
);

    localparam int unsigned PW = $clog2(CLK_DIV);
    localparam int unsigned FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [6:0]            SEG_OFF = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};

    logic [PW-1:0]           presc;
    logic [2:0]              idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [FW-1:0]           frame_cnt;
    logic                    phase;

    logic                    tick;
    logic                    last_digit;
    logic                    wrap;
    logic                    frame_last;
    logic [3:0]              nib;
    logic [6:0]              dec_seg;
    logic                    blank;
    logic [6:0]              seg_hi;
    logic                    dp_hi;
    logic [NUM_DIGITS-1:0]   an_hi;

    bcd_to_seg7 u_dec (
        .bcd (nib),
        .seg (dec_seg)
    );

    // Scan timing, snapshot and blink control decode
    always_comb begin
        tick       = i_en && (presc == PW'(CLK_DIV - 1));
        last_digit = (idx == 3'(NUM_DIGITS - 1));
        wrap       = tick && last_digit;
        frame_last = (frame_cnt == FW'(BLINK_DIV - 1));
    end

    // Active-high view of the digit currently selected by idx
    always_comb begin
        nib    = shadow[{idx, 2'b00} +: 4];
        blank  = phase && bus.i_blink_mask[field_of(idx)];
        seg_hi = blank ? 7'h00 : dec_seg;
        dp_hi  = !blank && bus.i_dp_mask[idx];
        an_hi  = NUM_DIGITS'(1) << idx;
    end

    // Prescaler, digit index, frame snapshot and blink phase
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            presc     <= '0;
            idx       <= '0;
            shadow    <= '0;
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (i_en) begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick)
                idx <= last_digit ? 3'd0 : idx + 3'd1;
            if (wrap) begin
                shadow    <= bus.i_time;
                frame_cnt <= frame_last ? '0 : frame_cnt + 1'b1;
                if (frame_last)
                    phase <= ~phase;
            end
        end
    end

    // Registered display drive with polarity applied
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            bus.o_seg   <= SEG_OFF;
            bus.o_dp    <= ACTIVE_LOW;
            bus.o_an    <= AN_OFF;
            bus.o_frame <= 1'b0;
        end else if (i_en) begin
            bus.o_seg   <= SEG_OFF ^ seg_hi;
            bus.o_dp    <= ACTIVE_LOW ^ dp_hi;
            bus.o_an    <= AN_OFF ^ an_hi;
            bus.o_frame <= wrap;
        end
    end

endmodule
